calc_entry_fsm: RTL and testbench

//  Downstream consumer of the cursor-grid key code. On each select pulse it latches the 5-bit key value.
//  - Digits are shifted into the active operand.
//  - Operators are stored. EXE computes A op B. CE clears the entry; CLR clears everything.
//  - Drives the display mux (disp) and the result/status flags read by the 7-seg/VGA front end.

---
 rtl/calc_entry_fsm_if.sv | 22 ++
 rtl/calc_entry_fsm.sv | 170 +++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/calc_entry_fsm_if.sv
// rtl/calc_entry_fsm_if.sv - key-entry input and display/status output bundle for calc_entry_fsm
interface calc_entry_fsm_if #(
    parameter int W = 16
);
    logic [4:0]   val;
    logic         sel;
    logic [W-1:0] disp;
    logic [2:0]   op;
    logic [1:0]   state;
    logic         result_valid;
    logic         overflow;

    modport master (
        output val, sel,
        input  disp, op, state, result_valid, overflow
    );

    modport slave (
        input  val, sel,
        output disp, op, state, result_valid, overflow
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - hex calculator entry state machine: operand entry, operator chaining, EXE
module calc_entry_fsm #(
    parameter int W      = 16,
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    calc_entry_fsm_if.slave bus
);
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, disp_q, disp_d;
    logic [2:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d, rv_q, rv_d;

    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [2:0]     key_op;
    logic           key_is_op;

    // Evaluate A op B with the currently latched operator; used by EXE and by chaining
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        prod    = a_q * b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            3'd1: begin alu_res = sum[W-1:0];  alu_ovf = sum[W];        end
            3'd2: begin alu_res = a_q - b_q;   alu_ovf = (b_q > a_q);   end
            3'd3: begin alu_res = prod[W-1:0]; alu_ovf = |prod[2*W-1:W]; end
            3'd4: begin alu_res = a_q & b_q;   alu_ovf = 1'b0;          end
            3'd5: begin alu_res = a_q | b_q;   alu_ovf = 1'b0;          end
            default: begin alu_res = '0;       alu_ovf = 1'b0;          end
        endcase
    end

    // Map operator key codes onto the internal operator encoding
    always_comb begin
        key_is_op = 1'b1;
        key_op    = 3'd0;
        case (bus.val)
            5'h10:   key_op = 3'd1;
            5'h14:   key_op = 3'd2;
            5'h11:   key_op = 3'd3;
            5'h12:   key_op = 3'd4;
            5'h15:   key_op = 3'd5;
            default: key_is_op = 1'b0;
        endcase
    end

    // Next-state decode for one accepted key press; codes 18-1F fall through untouched
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (bus.sel) begin
            if (bus.val == 5'h17 || (state_q == S_RES && bus.val == 5'h16)) begin
                state_d = S_A;
                a_d     = '0;
                b_d     = '0;
                r_d     = '0;
                op_d    = 3'd0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else if (bus.val <= 5'h0F) begin
                case (state_q)
                    S_A: if (cnt_q < CW'(DIGITS)) begin
                        a_d   = {a_q[W-5:0], bus.val[3:0]};
                        cnt_d = cnt_q + CW'(1);
                    end
                    S_B: if (cnt_q < CW'(DIGITS)) begin
                        b_d   = {b_q[W-5:0], bus.val[3:0]};
                        cnt_d = cnt_q + CW'(1);
                    end
                    default: begin
                        // Typing a digit over a result starts a fresh calculation
                        a_d     = {{(W-4){1'b0}}, bus.val[3:0]};
                        cnt_d   = CW'(1);
                        op_d    = 3'd0;
                        ovf_d   = 1'b0;
                        state_d = S_A;
                    end
                endcase
            end else if (key_is_op) begin
                case (state_q)
                    S_B: begin
                        a_d   = alu_res;
                        ovf_d = alu_ovf;
                    end
                    S_RES: a_d = r_q;
                    default: ;
                endcase
                op_d    = key_op;
                b_d     = '0;
                cnt_d   = '0;
                state_d = S_B;
            end else if (bus.val == 5'h13) begin
                if (state_q == S_B) begin
                    r_d     = alu_res;
                    ovf_d   = alu_ovf;
                    state_d = S_RES;
                end
            end else if (bus.val == 5'h16) begin
                if (state_q == S_A) begin
                    a_d   = '0;
                    cnt_d = '0;
                end else if (state_q == S_B) begin
                    b_d   = '0;
                    cnt_d = '0;
                end
            end
        end
    end

    // Display and result flag follow the next state so they line up with it
    always_comb begin
        case (state_d)
            S_A:     disp_d = a_d;
            S_B:     disp_d = b_d;
            S_RES:   disp_d = r_d;
            default: disp_d = '0;
        endcase
        rv_d = (state_d == S_RES);
    end

    // State and registered outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= 3'd0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.disp         = disp_q;
    assign bus.op           = op_q;
    assign bus.state        = state_q;
    assign bus.result_valid = rv_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - directed vector bench for calc_entry_fsm
module tb_calc_entry_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    calc_entry_fsm_if #(.W(16)) bus ();

    calc_entry_fsm #(.W(16), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  v;
        logic [15:0] disp;
        logic [2:0]  op;
        logic [1:0]  st;
        logic        rv;
        logic        ov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] v, input logic [15:0] d, input logic [2:0] o,
                       input logic [1:0] s, input logic r, input logic f);
        vec_t e;
        e.v = v; e.disp = d; e.op = o; e.st = s; e.rv = r; e.ov = f;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx, input logic [15:0] d, input logic [2:0] o,
                             input logic [1:0] s, input logic r, input logic f);
        check({name, ".disp"}, idx, 32'(bus.disp), 32'(d));
        check({name, ".op"}, idx, 32'(bus.op), 32'(o));
        check({name, ".state"}, idx, 32'(bus.state), 32'(s));
        check({name, ".rv"}, idx, 32'(bus.result_valid), 32'(r));
        check({name, ".ovf"}, idx, 32'(bus.overflow), 32'(f));
    endtask

    task automatic press(input logic [4:0] v);
        @(negedge clk);
        bus.val = v;
        bus.sel = 1'b1;
        @(negedge clk);
        bus.sel = 1'b0;
    endtask

    initial begin
        bus.val = 5'h00;
        bus.sel = 1'b0;

        // digit entry and 5th digit drop
        add(5'h01, 16'h0001, 0, 0, 0, 0);
        add(5'h02, 16'h0012, 0, 0, 0, 0);
        add(5'h03, 16'h0123, 0, 0, 0, 0);
        add(5'h04, 16'h1234, 0, 0, 0, 0);
        add(5'h05, 16'h1234, 0, 0, 0, 0);
        add(5'h17, 16'h0000, 0, 0, 0, 0);
        // 0x00FF + 1
        add(5'h0F, 16'h000F, 0, 0, 0, 0);
        add(5'h0F, 16'h00FF, 0, 0, 0, 0);
        add(5'h10, 16'h0000, 1, 1, 0, 0);
        add(5'h01, 16'h0001, 1, 1, 0, 0);
        add(5'h13, 16'h0100, 1, 2, 1, 0);
        // 0xFFFF + 2 carry, started by digit from S_RES
        add(5'h0F, 16'h000F, 0, 0, 0, 0);
        add(5'h0F, 16'h00FF, 0, 0, 0, 0);
        add(5'h0F, 16'h0FFF, 0, 0, 0, 0);
        add(5'h0F, 16'hFFFF, 0, 0, 0, 0);
        add(5'h10, 16'h0000, 1, 1, 0, 0);
        add(5'h02, 16'h0002, 1, 1, 0, 0);
        add(5'h13, 16'h0001, 1, 2, 1, 1);
        // 3 - 5 borrow
        add(5'h03, 16'h0003, 0, 0, 0, 0);
        add(5'h14, 16'h0000, 2, 1, 0, 0);
        add(5'h05, 16'h0005, 2, 1, 0, 0);
        add(5'h13, 16'hFFFE, 2, 2, 1, 1);
        // 0x100 * 0x100, then chain from R
        add(5'h17, 16'h0000, 0, 0, 0, 0);
        add(5'h01, 16'h0001, 0, 0, 0, 0);
        add(5'h00, 16'h0010, 0, 0, 0, 0);
        add(5'h00, 16'h0100, 0, 0, 0, 0);
        add(5'h11, 16'h0000, 3, 1, 0, 0);
        add(5'h01, 16'h0001, 3, 1, 0, 0);
        add(5'h00, 16'h0010, 3, 1, 0, 0);
        add(5'h00, 16'h0100, 3, 1, 0, 0);
        add(5'h13, 16'h0000, 3, 2, 1, 1);
        add(5'h10, 16'h0000, 1, 1, 0, 1);
        add(5'h01, 16'h0001, 1, 1, 0, 1);
        add(5'h13, 16'h0001, 1, 2, 1, 0);
        add(5'h13, 16'h0001, 1, 2, 1, 0);
        // 2 + 3 chained into * 4, then CE in S_RES
        add(5'h02, 16'h0002, 0, 0, 0, 0);
        add(5'h10, 16'h0000, 1, 1, 0, 0);
        add(5'h03, 16'h0003, 1, 1, 0, 0);
        add(5'h11, 16'h0000, 3, 1, 0, 0);
        add(5'h04, 16'h0004, 3, 1, 0, 0);
        add(5'h13, 16'h0014, 3, 2, 1, 0);
        add(5'h16, 16'h0000, 0, 0, 0, 0);
        // EXE ignored in S_A, CE in S_A and S_B
        add(5'h13, 16'h0000, 0, 0, 0, 0);
        add(5'h07, 16'h0007, 0, 0, 0, 0);
        add(5'h16, 16'h0000, 0, 0, 0, 0);
        add(5'h06, 16'h0006, 0, 0, 0, 0);
        add(5'h10, 16'h0000, 1, 1, 0, 0);
        add(5'h09, 16'h0009, 1, 1, 0, 0);
        add(5'h16, 16'h0000, 1, 1, 0, 0);
        add(5'h13, 16'h0006, 1, 2, 1, 0);
        // C & A chained into | 1
        add(5'h17, 16'h0000, 0, 0, 0, 0);
        add(5'h0C, 16'h000C, 0, 0, 0, 0);
        add(5'h12, 16'h0000, 4, 1, 0, 0);
        add(5'h0A, 16'h000A, 4, 1, 0, 0);
        add(5'h15, 16'h0000, 5, 1, 0, 0);
        add(5'h01, 16'h0001, 5, 1, 0, 0);
        add(5'h18, 16'h0001, 5, 1, 0, 0);
        add(5'h13, 16'h0009, 5, 2, 1, 0);

        repeat (2) @(negedge clk);
        check_all("reset", 0, 16'h0000, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].v);
            check_all("vec", i, tbl[i].disp, tbl[i].op, tbl[i].st, tbl[i].rv, tbl[i].ov);
        end

        // reset mid-entry of B clears outputs without waiting for a clock
        press(5'h17);
        press(5'h05);
        press(5'h10);
        press(5'h01);
        press(5'h02);
        check_all("mid_b", 0, 16'h0012, 1, 1, 0, 0);
        #2 rst = 1'b0;
        #1 check_all("async_rst", 0, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // sel held three cycles counts as three presses
        @(negedge clk);
        bus.val = 5'h07;
        bus.sel = 1'b1;
        repeat (3) @(negedge clk);
        bus.sel = 1'b0;
        check_all("held_sel", 0, 16'h0777, 0, 0, 0, 0);

        press(5'h1F);
        check_all("ignored_1f", 0, 16'h0777, 0, 0, 0, 0);

        // idle cycles with a digit on val must not change anything
        bus.val = 5'h03;
        repeat (4) @(negedge clk);
        check_all("sel_low", 0, 16'h0777, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
